calculator_core_seq: RTL
========================

# calculator_core_seq

Sequential, width-parametrised calculator core that succeeds the combinational add/subtract/multiply block. It adds unsigned restoring division with remainder, a start/busy/done handshake, registered and held results, and error flagging. Add, subtract and no-op complete in one cycle. Multiply and divide are iterative: one bit per clock, WIDTH iterations. It sits between the keypad/operand registers and the display formatter.

## Interface
- WIDTH, 16: operand width in bits (≥2); result width is 2*WIDTH
- IN_clk  in  1  system clock, rising-edge
- IN_reset  in  1  asynchronous, active-high reset
- IN_num1  in  WIDTH  unsigned operand A
- IN_num2  in  WIDTH  unsigned operand B
- IN_operation_code  in  4  one-hot opcode: [3] divide, [2] multiply, [1] subtract, [0] add; 0000 = no-op
- IN_start  in  1  request; sampled only when the core can accept
- OUT_answer  out  2*WIDTH  registered result, held until the next accepted start
- OUT_is_negative  out  1  subtract only: A < B
- OUT_error  out  1  divide-by-zero or multi-hot opcode
- OUT_busy  out  1  iterative operation in progress
- OUT_done  out  1  single-cycle pulse: result valid

## Operation
- States: IDLE, MUL, DIV, DONE. Reset forces IDLE.
- Accept: the core accepts on a rising edge with IN_start=1 and state IDLE or DONE. On accept it latches the operands and opcode and clears OUT_answer, OUT_is_negative and OUT_error. Later input changes have no effect.
- IN_start while in MUL or DIV is ignored. It is not queued.
- Add (0001): OUT_answer = zero-extended (WIDTH+1)-bit sum, carry at bit WIDTH. Written at the accept edge. Next state DONE.
- Subtract (0010): OUT_answer = zero-extended |A−B|. OUT_is_negative = (A<B). Next state DONE.
- No-op (0000): OUT_answer = 0, no error. Next state DONE.
- Multi-hot opcode: OUT_answer = 0, OUT_error = 1. Next state DONE.
- Multiply (0100): shift-add over WIDTH iterations. Result is the full 2*WIDTH-bit unsigned product. State MUL.
- Divide (1000): restoring division over WIDTH iterations.
  - OUT_answer[WIDTH-1:0] = quotient, OUT_answer[2W-1:W] = remainder.
  - B = 0: skip iteration, OUT_answer = 0, OUT_error = 1, next state DONE.
- Iteration counter: loaded with WIDTH at accept, decremented each edge in MUL/DIV. When the counter reaches 0, the final result is written to OUT_answer and the state moves to DONE.
- OUT_answer is not updated with partial results during iteration. It shows 0 until the result is written.
- DONE: OUT_done = 1 for exactly one cycle. The next state is IDLE, or a new accept if IN_start=1.
- OUT_is_negative is 0 for every non-subtract operation.

## Timing
- Reset values: OUT_answer = 0, OUT_is_negative = 0, OUT_error = 0, OUT_busy = 0, OUT_done = 0, counter = 0, state = IDLE.
- Reset is effective immediately and asynchronously, including mid-MUL/DIV. No done pulse follows a reset.
- Single-cycle ops: accept at edge k; OUT_done high in the cycle after edge k.
- Multiply and divide: accept at edge k; OUT_busy high from edge k to edge k+WIDTH; OUT_done high in the cycle after edge k+WIDTH. Latency is WIDTH+1 edges to done.
- OUT_busy and OUT_done are never high together.
- Back-to-back: start held high in DONE is accepted at that edge, so OUT_done is not stretched.
- The result, OUT_is_negative and OUT_error are stable from OUT_done until the next accept edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Add with carry (WIDTH=16): A=0xFFFF, B=0x0001, op=0001, start one cycle → done 1 cycle later; OUT_answer=0x00010000, neg=0, error=0.
- Subtract negative and positive: A=5, B=9, op=0010 → answer=4, neg=1. Then back-to-back A=9, B=5 → answer=4, neg=0; done pulses on consecutive accepts.
- Multiply full width: A=0xFFFF, B=0xFFFF, op=0100 → busy for 16 cycles, done at edge 17 after accept, answer=0xFFFE0001. Also check A=300, B=200 → 60000. Toggle the operands during busy → result unchanged.
- Divide and divide-by-zero: A=100, B=7, op=1000 → answer=0x0002000E (r=2, q=14) after 17 edges. A=100, B=0 → answer=0, error=1, done after 1 cycle.
- Error and ignore: op=0110 → answer=0, error=1, done after 1 cycle. Start pulses during MUL busy → no extra done, and the result matches the first operation.
- Reset mid-operation: assert IN_reset asynchronously at iteration 8 of a multiply → all outputs 0 immediately, no done pulse. After release, a new add completes normally.

Source files
------------

// File: rtl/calculator_core_seq.sv
// calculator_core_seq
// Sequential unsigned calculator core: add, subtract, shift-add multiply and
// restoring divide, with a start/busy/done handshake. The results are
// registered and held until the next accepted start.
//
// Ports
//   IN_clk             rising-edge system clock
//   IN_reset           asynchronous, active-high reset
//   IN_num1            operand A (unsigned, WIDTH bits)
//   IN_num2            operand B (unsigned, WIDTH bits)
//   IN_operation_code  one-hot opcode: [3] div, [2] mul, [1] sub, [0] add; 0000 = no-op
//   IN_start           request, sampled only in IDLE or DONE
//   OUT_answer         registered result (2*WIDTH); for divide it is {remainder, quotient}
//   OUT_is_negative    subtract only: A < B
//   OUT_error          divide-by-zero or multi-hot opcode
//   OUT_busy           multiply/divide iteration in progress
//   OUT_done           one-cycle pulse: result valid
module calculator_core_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 IN_clk,
  input  logic                 IN_reset,
  input  logic [WIDTH-1:0]     IN_num1,
  input  logic [WIDTH-1:0]     IN_num2,
  input  logic [3:0]           IN_operation_code,
  input  logic                 IN_start,
  output logic [2*WIDTH-1:0]   OUT_answer,
  output logic                 OUT_is_negative,
  output logic                 OUT_error,
  output logic                 OUT_busy,
  output logic                 OUT_done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] K_NOP = 3'd0;
  localparam logic [2:0] K_ADD = 3'd1;
  localparam logic [2:0] K_SUB = 3'd2;
  localparam logic [2:0] K_MUL = 3'd3;
  localparam logic [2:0] K_DIV = 3'd4;
  localparam logic [2:0] K_BAD = 3'd5;

  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]         state_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   mcand_r;      // multiplicand A
  logic [2*WIDTH:0]   mul_r;        // {carry, partial high, multiplier / low product}
  logic [WIDTH-1:0]   divisor_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;        // dividend bits shift out, quotient bits shift in

  logic [2:0]         op_kind_s;
  logic [WIDTH:0]     sum_s;
  logic               a_lt_b_s;
  logic [WIDTH-1:0]   diff_s;
  logic [WIDTH:0]     mul_add_s;
  logic [2*WIDTH:0]   mul_next_s;
  logic [WIDTH:0]     div_trial_s;
  logic [WIDTH:0]     div_sub_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic [WIDTH-1:0]   quo_next_s;

  // Decode the one-hot opcode; anything with more than one bit set is an error.
  always_comb begin
    op_kind_s = K_BAD;
    case (IN_operation_code)
      4'b0000: op_kind_s = K_NOP;
      4'b0001: op_kind_s = K_ADD;
      4'b0010: op_kind_s = K_SUB;
      4'b0100: op_kind_s = K_MUL;
      4'b1000: op_kind_s = K_DIV;
      default: op_kind_s = K_BAD;
    endcase
  end

  // Single-cycle arithmetic on the live operands, used only on the accept edge.
  always_comb begin
    sum_s    = {1'b0, IN_num1} + {1'b0, IN_num2};
    a_lt_b_s = (IN_num1 < IN_num2);
    if (a_lt_b_s) begin
      diff_s = IN_num2 - IN_num1;
    end else begin
      diff_s = IN_num1 - IN_num2;
    end
  end

  // One shift-add step: add A into the high half when the multiplier LSB is set,
  // then shift the whole register right by one.
  always_comb begin
    if (mul_r[0]) begin
      mul_add_s = mul_r[2*WIDTH:WIDTH] + {1'b0, mcand_r};
    end else begin
      mul_add_s = mul_r[2*WIDTH:WIDTH];
    end
    mul_next_s = {1'b0, mul_add_s, mul_r[WIDTH-1:1]};
  end

  // One restoring-division step: bring down the next dividend bit and subtract
  // the divisor only if it fits.
  always_comb begin
    div_trial_s = {rem_r, quo_r[WIDTH-1]};
    div_sub_s   = div_trial_s - {1'b0, divisor_r};
    if (div_trial_s >= {1'b0, divisor_r}) begin
      rem_next_s = div_sub_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_next_s = div_trial_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge IN_clk or posedge IN_reset) begin
    if (IN_reset) begin
      state_r         <= ST_IDLE;
      cnt_r           <= {CW{1'b0}};
      mcand_r         <= {WIDTH{1'b0}};
      mul_r           <= {(2*WIDTH+1){1'b0}};
      divisor_r       <= {WIDTH{1'b0}};
      rem_r           <= {WIDTH{1'b0}};
      quo_r           <= {WIDTH{1'b0}};
      OUT_answer      <= {(2*WIDTH){1'b0}};
      OUT_is_negative <= 1'b0;
      OUT_error       <= 1'b0;
      OUT_busy        <= 1'b0;
      OUT_done        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (IN_start) begin
            // Accept: clear the visible result, then launch the operation.
            OUT_answer      <= {(2*WIDTH){1'b0}};
            OUT_is_negative <= 1'b0;
            OUT_error       <= 1'b0;
            OUT_busy        <= 1'b0;
            OUT_done        <= 1'b1;
            state_r         <= ST_DONE;
            case (op_kind_s)
              K_NOP: begin
                OUT_answer <= {(2*WIDTH){1'b0}};
              end
              K_ADD: begin
                OUT_answer <= {{(WIDTH-1){1'b0}}, sum_s};
              end
              K_SUB: begin
                OUT_answer      <= {{WIDTH{1'b0}}, diff_s};
                OUT_is_negative <= a_lt_b_s;
              end
              K_MUL: begin
                mcand_r  <= IN_num1;
                mul_r    <= {{(WIDTH+1){1'b0}}, IN_num2};
                cnt_r    <= CNT_LOAD;
                OUT_busy <= 1'b1;
                OUT_done <= 1'b0;
                state_r  <= ST_MUL;
              end
              K_DIV: begin
                if (IN_num2 == {WIDTH{1'b0}}) begin
                  OUT_error <= 1'b1;
                end else begin
                  divisor_r <= IN_num2;
                  quo_r     <= IN_num1;
                  rem_r     <= {WIDTH{1'b0}};
                  cnt_r     <= CNT_LOAD;
                  OUT_busy  <= 1'b1;
                  OUT_done  <= 1'b0;
                  state_r   <= ST_DIV;
                end
              end
              default: begin
                OUT_error <= 1'b1;
              end
            endcase
          end else begin
            OUT_done <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_MUL: begin
          mul_r <= mul_next_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            OUT_answer <= mul_next_s[2*WIDTH-1:0];
            OUT_busy   <= 1'b0;
            OUT_done   <= 1'b1;
            state_r    <= ST_DONE;
          end
        end
        ST_DIV: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            OUT_answer <= {rem_next_s, quo_next_s};
            OUT_busy   <= 1'b0;
            OUT_done   <= 1'b1;
            state_r    <= ST_DONE;
          end
        end
        default: begin
          OUT_busy <= 1'b0;
          OUT_done <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
